// File: rtl/wb_stage.sv
// Write-back stage: classifies retiring instructions, queues register-file writes
// in a small FIFO, and offers a youngest-match bypass lookup plus debug counters.
module wb_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [4:0]          pc,
  input  logic [4:0]          opcode,
  input  logic signed [31:0]  aluout,
  input  logic signed [31:0]  LMD,
  input  logic [3:0]          destAddr,
  output logic                stall_out,
  input  logic                rf_ready,
  output logic                rf_we,
  output logic [3:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  input  logic [3:0]          fwd_qaddr,
  output logic                fwd_hit,
  output logic [31:0]         fwd_data,
  output logic [4:0]          last_pc,
  output logic [CNT_W-1:0]    retire_count,
  output logic [CNT_W-1:0]    illegal_count
);

  // Opcode encoding shared with the rest of the pipeline.
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ARSH = 5'd8;
  localparam logic [4:0] OP_LDW  = 5'd9;
  localparam logic [4:0] OP_STR  = 5'd10;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  // Handshakes: upstream transfers on a rising edge when in_valid=1 and
  // stall_out=0; a write transfers on a rising edge when rf_we=1 and rf_ready=1.
  // Neither valid depends combinationally on its ready.

  logic [3:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [4:0]       pc_mem   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  logic             accept;
  logic             is_alu;
  logic             is_ldw;
  logic             is_skip;
  logic             is_illegal;
  logic             push;
  logic             pop;
  logic [31:0]      push_data;
  logic [PTR_W-1:0] scan_idx;

  // ---------------------------------------------------------------------------
  // Classification of the presented instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    is_alu     = (opcode > OP_NOP) && (opcode <= OP_ARSH);
    is_ldw     = (opcode == OP_LDW);
    is_skip    = (opcode == OP_NOP) || (opcode == OP_STR);
    is_illegal = !(is_alu || is_ldw || is_skip);
    push_data  = is_ldw ? LMD : aluout;
  end

  assign stall_out = (occ == FULL_OCC);
  assign accept    = in_valid && !stall_out;
  assign push      = accept && (is_alu || is_ldw);
  assign pop       = rf_we && rf_ready;

  // ---------------------------------------------------------------------------
  // Head issue: purely from stored state, zeroed when nothing is pending
  // ---------------------------------------------------------------------------
  assign rf_we    = (occ != '0);
  assign rf_waddr = rf_we ? addr_mem[rd_ptr] : 4'd0;
  assign rf_wdata = rf_we ? data_mem[rd_ptr] : 32'd0;

  // ---------------------------------------------------------------------------
  // Storage (no reset needed: occupancy qualifies every read)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= destAddr;
      data_mem[wr_ptr] <= push_data;
      pc_mem[wr_ptr]   <= pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Retire bookkeeping and illegal-opcode counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc       <= '0;
      retire_count  <= '0;
      illegal_count <= '0;
    end else begin
      if (pop) begin
        last_pc      <= pc_mem[rd_ptr];
        retire_count <= retire_count + 1'b1;
      end
      if (accept && is_illegal) illegal_count <= illegal_count + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Bypass: walk oldest to youngest so the last match left standing is youngest
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 32'd0;
    scan_idx = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PTR_W'(i);
      if ((OCC_W'(i) < occ) && (addr_mem[scan_idx] == fwd_qaddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[scan_idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected register writes,
// directed scenarios for latency, backpressure, bypass, reset and counter wrap.
module tb_wb_stage;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_ARSH = 5'd8;
  localparam logic [4:0] OP_LDW  = 5'd9;
  localparam logic [4:0] OP_STR  = 5'd10;
  localparam logic [4:0] OP_BAD  = 5'd20;
  localparam int W = 41;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic [4:0]         pc;
  logic [4:0]         opcode;
  logic signed [31:0] aluout;
  logic signed [31:0] lmd;
  logic [3:0]         dest_addr;
  logic               stall_out;
  logic               rf_ready;
  logic               rf_we;
  logic [3:0]         rf_waddr;
  logic [31:0]        rf_wdata;
  logic [3:0]         fwd_qaddr;
  logic               fwd_hit;
  logic [31:0]        fwd_data;
  logic [4:0]         last_pc;
  logic [15:0]        retire_count;
  logic [15:0]        illegal_count;

  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_retire;
  logic [15:0]  exp_illegal;
  logic [4:0]   exp_last_pc;
  int           n_checks;
  int           n_fail;

  wb_stage #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .pc(pc), .opcode(opcode),
    .aluout(aluout), .LMD(lmd), .destAddr(dest_addr), .stall_out(stall_out),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_qaddr(fwd_qaddr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .last_pc(last_pc), .retire_count(retire_count), .illegal_count(illegal_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: a write transfers at the next rising edge if rf_we && rf_ready now.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && rf_we && rf_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {60'd0, rf_waddr}, 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("rf_waddr", rf_waddr, e[40:37]);
        check("rf_wdata", rf_wdata, e[36:5]);
        exp_retire  = exp_retire + 16'd1;
        exp_last_pc = e[4:0];
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic expect_accept(input logic [4:0] op, input logic [3:0] dst,
                               input logic [31:0] alu, input logic [31:0] ld,
                               input logic [4:0] p);
    if (op > OP_NOP && op <= OP_ARSH) exp_q.push_back({dst, alu, p});
    else if (op == OP_LDW)            exp_q.push_back({dst, ld, p});
    else if (op != OP_NOP && op != OP_STR) exp_illegal = exp_illegal + 16'd1;
  endtask

  // Called and returns at posedge+2; holds the instruction until accepted.
  task automatic send(input logic [4:0] op, input logic [3:0] dst,
                      input logic [31:0] alu, input logic [31:0] ld,
                      input logic [4:0] p);
    int  waited;
    bit  done;
    waited = 0;
    done = 0;
    opcode = op; dest_addr = dst; aluout = alu; lmd = ld; pc = p;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (!stall_out) begin
        expect_accept(op, dst, alu, ld, p);
        done = 1;
      end else if (++waited > 50) begin
        check("accept_timeout", 64'd0, 64'd1);
        done = 1;
      end
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    rf_ready = 1'b1;
    while ((exp_q.size() != 0 || rf_we) && waited < 100) begin
      @(posedge clk); #2;
      waited++;
    end
    if (waited >= 100) check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic rand_instr();
    opcode    = ($urandom_range(0, 3) == 0) ? OP_LDW : 5'($urandom_range(1, 8));
    dest_addr = 4'($urandom_range(0, 15));
    aluout    = $urandom;
    lmd       = $urandom;
    pc        = 5'($urandom_range(0, 31));
  endtask

  // Back-to-back accepts with the write port always ready.
  task automatic stream(input int n);
    int left;
    int guard;
    left = n;
    guard = 0;
    rf_ready = 1'b1;
    rand_instr();
    in_valid = 1'b1;
    while (left > 0 && guard < n + 1000) begin
      @(negedge clk);
      guard++;
      if (!stall_out) begin
        expect_accept(opcode, dest_addr, aluout, lmd, pc);
        left--;
        @(posedge clk); #2;
        rand_instr();
      end else begin
        @(posedge clk); #2;
      end
    end
    in_valid = 1'b0;
    if (left > 0) check("stream_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_fail = 0;
    exp_retire = 16'd0; exp_illegal = 16'd0; exp_last_pc = 5'd0;
    rst = 1'b1; in_valid = 1'b0; pc = '0; opcode = '0; aluout = '0; lmd = '0;
    dest_addr = '0; rf_ready = 1'b0; fwd_qaddr = 4'd0;
    #3;
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_rf_waddr", rf_waddr, 4'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_fwd_hit", fwd_hit, 1'b0);
    check("rst_fwd_data", fwd_data, 32'd0);
    check("rst_last_pc", last_pc, 5'd0);
    check("rst_retire", retire_count, 16'd0);
    check("rst_illegal", illegal_count, 16'd0);
    check("rst_stall", stall_out, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Single ADD: one-cycle latency, sign pattern passed through.
    rf_ready = 1'b1;
    send(OP_ADD, 4'd5, 32'hFFFFFFF9, 32'd0, 5'd3);
    @(negedge clk);
    check("add_rf_we", rf_we, 1'b1);
    check("add_rf_waddr", rf_waddr, 4'd5);
    check("add_rf_wdata", rf_wdata, 32'hFFFFFFF9);
    @(posedge clk); #2;
    @(negedge clk);
    check("add_retire", retire_count, 16'd1);
    check("add_last_pc", last_pc, 5'd3);
    check("add_idle", rf_we, 1'b0);
    @(posedge clk); #2;

    // LDW selects load data; STR and NOP produce nothing.
    send(OP_LDW, 4'd2, 32'h99, 32'h1234, 5'd7);
    drain();
    check("ldw_retire", retire_count, 16'd2);
    check("ldw_last_pc", last_pc, 5'd7);
    send(OP_STR, 4'd6, 32'h55, 32'h66, 5'd8);
    @(negedge clk);
    check("str_no_write", rf_we, 1'b0);
    @(posedge clk); #2;
    send(OP_NOP, 4'd7, 32'h77, 32'h88, 5'd9);
    @(negedge clk);
    check("nop_no_write", rf_we, 1'b0);
    check("skip_retire", retire_count, 16'd2);
    @(posedge clk); #2;

    // Backpressure: two accepts fill the FIFO, third held until a slot frees.
    rf_ready = 1'b0;
    send(OP_ADD, 4'd1, 32'd100, 32'd0, 5'd11);
    send(OP_SUB, 4'd2, 32'd200, 32'd0, 5'd12);
    @(negedge clk);
    check("full_stall", stall_out, 1'b1);
    check("full_head_addr", rf_waddr, 4'd1);
    @(posedge clk); #2;
    fork
      send(OP_ARSH, 4'd3, 32'd300, 32'd0, 5'd13);
      begin
        repeat (3) begin
          @(negedge clk);
          check("held_stall", stall_out, 1'b1);
          check("held_head_data", rf_wdata, 32'd100);
        end
        @(posedge clk); #2;
        rf_ready = 1'b1;
      end
    join
    drain();
    check("bp_retire", retire_count, 16'd5);
    check("bp_last_pc", last_pc, 5'd13);

    // Bypass: youngest match wins, misses return zero, popping entry still hits.
    rf_ready = 1'b0;
    send(OP_ADD, 4'd4, 32'd10, 32'd0, 5'd14);
    send(OP_ADD, 4'd4, 32'd20, 32'd0, 5'd15);
    fwd_qaddr = 4'd4; #1;
    check("fwd_hit_young", fwd_hit, 1'b1);
    check("fwd_data_young", fwd_data, 32'd20);
    fwd_qaddr = 4'd6; #1;
    check("fwd_miss_hit", fwd_hit, 1'b0);
    check("fwd_miss_data", fwd_data, 32'd0);
    fwd_qaddr = 4'd4;
    rf_ready = 1'b1;
    @(posedge clk); #2;
    check("fwd_pop_hit", fwd_hit, 1'b1);
    check("fwd_pop_data", fwd_data, 32'd20);
    drain();
    check("fwd_empty_hit", fwd_hit, 1'b0);
    rf_ready = 1'b0;
    send(OP_LDW, 4'd9, 32'd0, 32'd30, 5'd16);
    send(OP_ADD, 4'd0, 32'd40, 32'd0, 5'd17);
    fwd_qaddr = 4'd9; #1;
    check("fwd_old_hit", fwd_hit, 1'b1);
    check("fwd_old_data", fwd_data, 32'd30);
    fwd_qaddr = 4'd0; #1;
    check("fwd_r0_data", fwd_data, 32'd40);
    drain();
    check("fwd_retire", retire_count, exp_retire);

    // Illegal opcode: counted, never written.
    send(OP_BAD, 4'd8, 32'd1, 32'd2, 5'd18);
    @(negedge clk);
    check("bad_no_write", rf_we, 1'b0);
    check("bad_count", illegal_count, 16'd1);
    check("bad_count_model", illegal_count, exp_illegal);
    @(posedge clk); #2;

    // Asynchronous reset mid-stream with two writes pending.
    rf_ready = 1'b0;
    send(OP_ADD, 4'd1, 32'd500, 32'd0, 5'd19);
    send(OP_ADD, 4'd2, 32'd600, 32'd0, 5'd20);
    fwd_qaddr = 4'd1;
    @(posedge clk); #4;
    rst = 1'b1;
    exp_q.delete();
    exp_retire = 16'd0; exp_illegal = 16'd0; exp_last_pc = 5'd0;
    #1;
    check("mid_rst_rf_we", rf_we, 1'b0);
    check("mid_rst_retire", retire_count, 16'd0);
    check("mid_rst_last_pc", last_pc, 5'd0);
    check("mid_rst_illegal", illegal_count, 16'd0);
    check("mid_rst_stall", stall_out, 1'b0);
    check("mid_rst_fwd_hit", fwd_hit, 1'b0);
    @(posedge clk); #4;
    rst = 1'b0;
    rf_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_idle", rf_we, 1'b0);
    end
    @(posedge clk); #2;

    // Retire counter wrap.
    stream(65535);
    drain();
    check("wrap_pre", retire_count, 16'hFFFF);
    check("wrap_pre_pc", last_pc, exp_last_pc);
    send(OP_SUB, 4'd15, 32'h8000_0000, 32'd0, 5'd31);
    drain();
    check("wrap_zero", retire_count, 16'h0000);
    check("wrap_last_pc", last_pc, 5'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the PIGRO pipeline. Sits directly downstream of the memory stage.
- Accepts each retiring instruction (PC, opcode, ALU result, load data, destination register) and decides whether it writes the register file. LDW selects load data; arithmetic/logic ops select the ALU result.
- Buffers pending writes in a small FIFO because the register-file write port can be busy.
- Provides a youngest-match bypass lookup for earlier stages and keeps a retire counter for debug.

Parameters:
DEPTH, 2, number of pending-write FIFO entries (power of two, 2..8)
CNT_W, 16, width of retire and illegal-opcode counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  memory stage presents an instruction this cycle
pc  input  5  PC of presented instruction
opcode  input  5  opcode of presented instruction (codebase opcode macros)
aluout  input  32  signed ALU result forwarded by memory stage
LMD  input  32  signed load memory data
destAddr  input  4  destination register address
stall_out  output  1  FIFO full; upstream must hold its instruction
rf_ready  input  1  register-file write port accepts a write this cycle
rf_we  output  1  write request valid
rf_waddr  output  4  register address to write
rf_wdata  output  32  data to write
fwd_qaddr  input  4  bypass query register address
fwd_hit  output  1  a pending entry targets fwd_qaddr
fwd_data  output  32  data of youngest matching pending entry
last_pc  output  5  PC of last instruction whose write completed
retire_count  output  CNT_W  number of completed register writes
illegal_count  output  CNT_W  number of accepted instructions with unknown opcode

Behaviour:
- Reset (async, rst=1): FIFO empty, read/write pointers and occupancy 0. rf_we=0, rf_waddr=0, rf_wdata=0, fwd_hit=0, fwd_data=0, last_pc=0, retire_count=0, illegal_count=0, stall_out=0.
- Reset mid-operation discards all pending writes. No partial write is issued after rst rises.
- Accept: an instruction is accepted on a rising edge when in_valid=1 and stall_out=0. stall_out is 1 exactly when occupancy==DEPTH.
- Classification at accept:
  - opcode strictly between NOP and ARSH, inclusive of ARSH: push {destAddr, aluout, pc}.
  - LDW: push {destAddr, LMD, pc}.
  - NOP or STR: consumed, no push, no count change.
  - Any other opcode: consumed, no push, illegal_count+1 (wraps).
- Issue: rf_we=1 whenever occupancy>0. rf_waddr and rf_wdata come from the FIFO head and are driven from state registers only (no combinational path from in_* inputs).
- A write completes on an edge where rf_we=1 and rf_ready=1. On completion: pop head, retire_count+1 (wraps modulo 2^CNT_W), last_pc updated to the head PC.
- Head outputs are stable while rf_ready=0.
- Latency: an instruction accepted at edge N into an empty FIFO has rf_we=1 in the cycle after edge N. If rf_ready=1 it completes at edge N+1.
- Simultaneous push and pop: occupancy unchanged.
  - When full, a pop frees a slot only for the next cycle, since stall_out is evaluated from the pre-edge occupancy.
  - When empty, a push and a pop cannot occur on the same edge; there is no fall-through.
- Pointer wrap: read and write pointers wrap modulo DEPTH. Occupancy is tracked separately so full and empty are unambiguous.
- Bypass (combinational on fwd_qaddr and FIFO state):
  - fwd_hit=1 if any valid entry has address == fwd_qaddr.
  - fwd_data is the data of the youngest such entry (closest to the write pointer). fwd_data=0 when there is no hit.
  - The entry being popped this cycle still counts as a hit.
- All 16 register addresses, including 0, are writable. The register file decides any special treatment of address 0.
- Arithmetic: data is passed through unmodified, with no sign or width change.

Test Plan:
1. Reset mid-stream: 2 entries pending, rst pulsed asynchronously between edges -> rf_we, counters, last_pc go 0 immediately; no rf write after release until a new accept.
2. Single ADD: pc=3, destAddr=5, aluout=-7, rf_ready=1 -> rf_we=1 one cycle later with rf_waddr=5, rf_wdata=0xFFFFFFF9; after the next edge retire_count=1, last_pc=3.
3. LDW vs STR vs NOP: LDW destAddr=2 LMD=0x1234 aluout=0x99 -> writes 0x1234. STR and NOP -> no rf_we, retire_count unchanged.
4. Backpressure: rf_ready=0, three valid ALU ops to r1/r2/r3 -> stall_out=1 after two accepts and the third is held. Raise rf_ready -> writes in order r1, r2, r3; retire_count=3.
5. Bypass: pending r4=10 then r4=20, fwd_qaddr=4 -> fwd_hit=1, fwd_data=20. fwd_qaddr=6 -> fwd_hit=0, fwd_data=0.
6. Illegal opcode and wrap: unused opcode value -> illegal_count=1, no write. Preload retire_count to 0xFFFF and complete one write -> count 0.
